// File: rtl/core_pkg.sv
// Shared trap-controller types: FSM states, trap kinds and machine exception cause codes.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } trap_state_t;

    typedef enum logic [1:0] {
        KIND_EXC_EX = 2'd0,
        KIND_EXC_ID = 2'd1,
        KIND_MRET   = 2'd2
    } trap_kind_t;

    localparam logic [4:0] EXC_INSTR_MISALIGNED = 5'd0;
    localparam logic [4:0] EXC_ILLEGAL_INSTR    = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT       = 5'd3;
    localparam logic [4:0] EXC_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] EXC_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] EXC_ECALL_M          = 5'd11;

    // mret target alignment: halfword with compressed ISA, word otherwise.
    function automatic logic [31:0] mret_target(input logic [31:0] mepc, input bit isa_c);
        return isa_c ? (mepc & 32'hFFFF_FFFE) : (mepc & 32'hFFFF_FFFC);
    endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap controller: accepts one exception/mret event at a time, flushes the pipeline
// for one cycle, then holds a fetch redirect until fetch accepts it.
module trap_ctrl
    import core_pkg::*;
#(
    parameter int ISA_C = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exc_id_valid_i,
    input  logic [4:0]  exc_id_cause_i,
    input  logic        exc_ex_valid_i,
    input  logic [4:0]  exc_ex_cause_i,
    input  logic        mret_id_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        fetch_ready_i,
    output logic        save_pc_id_o,
    output logic        save_pc_ex_o,
    output logic [4:0]  exception_cause_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        stall_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    trap_state_t state_q, state_d;
    trap_kind_t  kind_q, kind_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] pc_q, pc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kind_q  <= KIND_EXC_EX;
            cause_q <= 5'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        save_pc_id_o     = 1'b0;
        save_pc_ex_o     = 1'b0;
        flush_if_o       = 1'b0;
        flush_id_o       = 1'b0;
        flush_ex_o       = 1'b0;
        stall_o          = 1'b0;
        redirect_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                // EX is older than ID, so its exception wins; mret only when no exception.
                if (exc_ex_valid_i) begin
                    stall_o = 1'b1;
                    state_d = FLUSH;
                    kind_d  = KIND_EXC_EX;
                    cause_d = exc_ex_cause_i;
                end else if (exc_id_valid_i) begin
                    stall_o = 1'b1;
                    state_d = FLUSH;
                    kind_d  = KIND_EXC_ID;
                    cause_d = exc_id_cause_i;
                end else if (mret_id_i) begin
                    stall_o = 1'b1;
                    state_d = FLUSH;
                    kind_d  = KIND_MRET;
                end
            end
            FLUSH: begin
                flush_if_o   = 1'b1;
                flush_id_o   = 1'b1;
                flush_ex_o   = 1'b1;
                stall_o      = 1'b1;
                save_pc_ex_o = (kind_q == KIND_EXC_EX);
                save_pc_id_o = (kind_q == KIND_EXC_ID);
                state_d      = REDIRECT;
                pc_d         = (kind_q == KIND_MRET) ? mret_target(mepc_i, ISA_C != 0)
                                                     : (mtvec_i & 32'hFFFF_FFFC);
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                stall_o          = 1'b1;
                if (fetch_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset overrides every strobe in the cycle it is asserted.
        if (rst_i) begin
            save_pc_id_o     = 1'b0;
            save_pc_ex_o     = 1'b0;
            flush_if_o       = 1'b0;
            flush_id_o       = 1'b0;
            flush_ex_o       = 1'b0;
            stall_o          = 1'b0;
            redirect_valid_o = 1'b0;
        end
    end

    assign exception_cause_o = cause_q;
    assign redirect_pc_o     = pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: two instances (ISA_C=0 and ISA_C=1) share stimulus.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_v, ex_v, mret, ready;
    logic [4:0]  id_c, ex_c;
    logic [31:0] mtvec, mepc;

    logic        s_id, s_ex, f_if, f_id, f_ex, stall, rv;
    logic [4:0]  cause;
    logic [31:0] rpc;

    logic        c_s_id, c_s_ex, c_f_if, c_f_id, c_f_ex, c_stall, c_rv;
    logic [4:0]  c_cause;
    logic [31:0] c_rpc;
    logic [6:0]  c_ctl;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.ISA_C(0)) dut (
        .clk_i(clk), .rst_i(rst),
        .exc_id_valid_i(id_v), .exc_id_cause_i(id_c),
        .exc_ex_valid_i(ex_v), .exc_ex_cause_i(ex_c),
        .mret_id_i(mret), .mtvec_i(mtvec), .mepc_i(mepc), .fetch_ready_i(ready),
        .save_pc_id_o(s_id), .save_pc_ex_o(s_ex), .exception_cause_o(cause),
        .flush_if_o(f_if), .flush_id_o(f_id), .flush_ex_o(f_ex),
        .stall_o(stall), .redirect_valid_o(rv), .redirect_pc_o(rpc)
    );

    trap_ctrl #(.ISA_C(1)) dut_c (
        .clk_i(clk), .rst_i(rst),
        .exc_id_valid_i(id_v), .exc_id_cause_i(id_c),
        .exc_ex_valid_i(ex_v), .exc_ex_cause_i(ex_c),
        .mret_id_i(mret), .mtvec_i(mtvec), .mepc_i(mepc), .fetch_ready_i(ready),
        .save_pc_id_o(c_s_id), .save_pc_ex_o(c_s_ex), .exception_cause_o(c_cause),
        .flush_if_o(c_f_if), .flush_id_o(c_f_id), .flush_ex_o(c_f_ex),
        .stall_o(c_stall), .redirect_valid_o(c_rv), .redirect_pc_o(c_rpc)
    );

    assign c_ctl = {c_s_id, c_s_ex, c_f_if, c_f_id, c_f_ex, c_stall, c_rv};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_events();
        id_v = 1'b0; ex_v = 1'b0; mret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ready = 1'b0; id_c = 5'd0; ex_c = 5'd0;
        mtvec = 32'h0; mepc = 32'h0;
        clear_events();
        tick(); tick();

        // Reset cycle with an event present: no stall.
        ex_v = 1'b1; ex_c = 5'd4; #1;
        check("rst_stall", 32'(stall), 32'd0);
        tick();
        clear_events(); rst = 1'b0; #1;
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_rv", 32'(rv), 32'd0);
        check("idle_pc", rpc, 32'h0);
        check("idle_cause", 32'(cause), 32'd0);

        // EX misaligned load, cause 4.
        ex_v = 1'b1; ex_c = 5'd4; mtvec = 32'h0000_0100; #1;
        check("ex_evt_stall", 32'(stall), 32'd1);
        check("ex_evt_save", 32'({s_id, s_ex}), 32'd0);
        tick(); clear_events(); #1;
        check("ex_fl_save_ex", 32'(s_ex), 32'd1);
        check("ex_fl_save_id", 32'(s_id), 32'd0);
        check("ex_fl_cause", 32'(cause), 32'd4);
        check("ex_fl_flush", 32'({f_if, f_id, f_ex}), 32'd7);
        check("ex_fl_stall", 32'(stall), 32'd1);
        check("ex_fl_rv", 32'(rv), 32'd0);
        tick();
        check("ex_rd_rv", 32'(rv), 32'd1);
        check("ex_rd_pc", rpc, 32'h100);
        check("ex_rd_stall", 32'(stall), 32'd1);
        check("ex_rd_save", 32'({s_id, s_ex}), 32'd0);
        ready = 1'b1;
        tick();
        check("ex_back_rv", 32'(rv), 32'd0);
        check("ex_back_stall", 32'(stall), 32'd0);
        check("ex_back_cause", 32'(cause), 32'd4);

        // ID cause 2 and EX cause 6 together: EX wins; mtvec low bits dropped.
        id_v = 1'b1; id_c = 5'd2; ex_v = 1'b1; ex_c = 5'd6; mtvec = 32'h0000_0203;
        tick(); clear_events(); #1;
        check("pri_save_ex", 32'(s_ex), 32'd1);
        check("pri_save_id", 32'(s_id), 32'd0);
        check("pri_cause", 32'(cause), 32'd6);
        tick();
        check("pri_rd_pc", rpc, 32'h200);
        tick();

        // mret in the IDLE cycle right after REDIRECT is accepted.
        check("b2b_rv", 32'(rv), 32'd0);
        mret = 1'b1; mepc = 32'h0000_2006; #1;
        check("mret_evt_stall", 32'(stall), 32'd1);
        tick(); clear_events(); #1;
        check("mret_fl_save", 32'({s_id, s_ex}), 32'd0);
        check("mret_fl_flush", 32'({f_if, f_id, f_ex}), 32'd7);
        check("mret_fl_cause", 32'(cause), 32'd6);
        check("mret_c_fl_ctl", 32'(c_ctl), 32'b0011110);
        tick();
        check("mret_pc_isa0", rpc, 32'h2004);
        check("mret_pc_isa1", c_rpc, 32'h2006);
        check("mret_c_rd_ctl", 32'(c_ctl), 32'b0000011);
        check("mret_c_cause", 32'(c_cause), 32'd6);
        tick();

        // ID illegal instr, fetch stalls 5 cycles; ecall during wait ignored.
        ready = 1'b0;
        id_v = 1'b1; id_c = 5'd2; mtvec = 32'h0000_0400;
        tick(); clear_events(); #1;
        check("id_fl_save_id", 32'(s_id), 32'd1);
        check("id_fl_save_ex", 32'(s_ex), 32'd0);
        check("id_fl_cause", 32'(cause), 32'd2);
        tick();
        mtvec = 32'h0000_0800;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wait%0d_rv", i), 32'(rv), 32'd1);
            check($sformatf("wait%0d_pc", i), rpc, 32'h400);
            if (i == 1) begin
                id_v = 1'b1; id_c = 5'd11;
            end else begin
                clear_events();
            end
            tick();
        end
        check("wait_cause", 32'(cause), 32'd2);
        check("wait_save", 32'({s_id, s_ex}), 32'd0);
        ready = 1'b1;
        tick();
        check("wait_back_rv", 32'(rv), 32'd0);
        check("wait_back_stall", 32'(stall), 32'd0);

        // Reset asserted in FLUSH.
        ex_v = 1'b1; ex_c = 5'd4; mtvec = 32'h0000_0100;
        tick(); clear_events();
        rst = 1'b1; #1;
        check("rstfl_save", 32'({s_id, s_ex}), 32'd0);
        check("rstfl_stall", 32'(stall), 32'd0);
        check("rstfl_flush", 32'({f_if, f_id, f_ex}), 32'd0);
        tick();
        rst = 1'b0; #1;
        check("rstfl_rv", 32'(rv), 32'd0);
        check("rstfl_pc", rpc, 32'h0);
        check("rstfl_cause", 32'(cause), 32'd0);
        tick();
        check("rstfl_idle_rv", 32'(rv), 32'd0);
        check("rstfl_idle_stall", 32'(stall), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
